tnet_tx_queue: RTL and testbench

Transmit-side command queue for the tNet link controller. Buffers outgoing network commands from the processor side, builds the 64-bit tNet header (opcode, flags, destination, own ID as source, step 0), and presents one header/data pair at a time on the controller's `tx_req`/`tx_ack` four-phase handshake. It sits directly upstream of the Aurora link controller and runs in `user_clk_i`. It retries transfers that the link aborts.

---
 rtl/tnet_pkg.sv | 49 ++++
 rtl/tnet_tx_fifo.sv | 57 +++++
 rtl/tnet_tx_queue.sv | 117 +++++++++++
 tb/tb_tnet_tx_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tnet_pkg.sv
// Shared tNet definitions: header field map, special constants and the TX queue state encoding.
package tnet_pkg;

    localparam int OP_LSB    = 56;
    localparam int OP_W      = 4;
    localparam int FLAGS_LSB = 50;
    localparam int FLAGS_W   = 6;
    localparam int DST_LSB   = 40;
    localparam int DST_W     = 10;
    localparam int SRC_LSB   = 30;
    localparam int SRC_W     = 10;
    localparam int STEP_LSB  = 20;
    localparam int STEP_W    = 10;
    localparam int HDT_LSB   = 0;
    localparam int HDT_W     = 20;
    localparam int DATA_W    = 64;

    // Queue entry layout, MSB first: {op, flags, dst, hdt, data}
    localparam int ENTRY_W = OP_W + FLAGS_W + DST_W + HDT_W + DATA_W;

    localparam int               SYNC_BIT  = 5;
    localparam logic [DST_W-1:0] DST_BCAST = 10'h3FF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_REL   = 2'd2,
        ST_ABORT = 2'd3
    } tq_st_t;

    function automatic logic [63:0] build_header(
        input logic [OP_W-1:0]    op,
        input logic [FLAGS_W-1:0] flags,
        input logic [DST_W-1:0]   dst,
        input logic [SRC_W-1:0]   src,
        input logic [HDT_W-1:0]   hdt
    );
        logic [63:0] h;
        h = '0;
        h[OP_LSB +: OP_W]       = op;
        h[FLAGS_LSB +: FLAGS_W] = flags;
        h[DST_LSB +: DST_W]     = dst;
        h[SRC_LSB +: SRC_W]     = src;
        h[STEP_LSB +: STEP_W]   = '0;
        h[HDT_LSB +: HDT_W]     = hdt;
        return h;
    endfunction

endpackage

// File: rtl/tnet_tx_fifo.sv
// Show-ahead FIFO for queued TX commands: the head entry is readable the cycle after it is written.
module tnet_tx_fifo
    import tnet_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = ENTRY_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tnet_tx_queue.sv
// tNet transmit queue: buffers commands, builds headers and drives the tx_req/tx_ack
// four-phase handshake, retrying any transfer the link aborts.
module tnet_tx_queue
    import tnet_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int ACK_TO     = 1023
) (
    input  logic                  user_clk_i,
    input  logic                  user_rst_i,
    input  logic [SRC_W-1:0]      ID,
    input  logic                  link_ready_i,
    input  logic                  s_cmd_valid_i,
    output logic                  s_cmd_ready_o,
    input  logic [OP_W-1:0]       s_cmd_op_i,
    input  logic [FLAGS_W-1:0]    s_cmd_flags_i,
    input  logic [DST_W-1:0]      s_cmd_dst_i,
    input  logic [HDT_W-1:0]      s_cmd_hdt_i,
    input  logic [DATA_W-1:0]     s_cmd_data_i,
    output logic                  tx_req_o,
    output logic [63:0]           tx_header_o,
    output logic [DATA_W-1:0]     tx_data_o,
    input  logic                  tx_ack_i,
    output logic [DEPTH_LOG2:0]   q_cnt_o,
    output logic [7:0]            err_cnt_o,
    output logic [1:0]            state_o
);

    tq_st_t              state_q;
    logic                req_q;
    logic [63:0]         header_q;
    logic [DATA_W-1:0]   data_q;
    logic [9:0]          timer_q;
    logic [7:0]          err_cnt_q;
    logic [7:0]          err_cnt_d;
    logic [ENTRY_W-1:0]  head;
    logic                full;
    logic                empty;
    logic                pop;
    logic                timeout;
    logic                err_inc;

    tnet_tx_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (ENTRY_W)
    ) u_fifo (
        .clk_i   (user_clk_i),
        .rst_i   (user_rst_i),
        .push_i  (s_cmd_valid_i),
        .wdata_i ({s_cmd_op_i, s_cmd_flags_i, s_cmd_dst_i, s_cmd_hdt_i, s_cmd_data_i}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (q_cnt_o)
    );

    assign s_cmd_ready_o = ~full;
    assign timeout       = (timer_q == 10'(ACK_TO));
    // The head leaves the queue only once the release phase completes with the link still up.
    assign pop           = (state_q == ST_REL) & ~tx_ack_i & link_ready_i;
    assign err_inc       = ((state_q == ST_REQ) & ~tx_ack_i & (timeout | ~link_ready_i))
                         | ((state_q == ST_REL) & ~tx_ack_i & ~link_ready_i);
    assign err_cnt_d     = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;

    always_ff @(posedge user_clk_i or posedge user_rst_i) begin
        if (user_rst_i) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            header_q  <= '0;
            data_q    <= '0;
            timer_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    if (~empty & link_ready_i) begin
                        header_q <= build_header(head[ENTRY_W-1 -: OP_W],
                                                 head[ENTRY_W-OP_W-1 -: FLAGS_W],
                                                 head[DATA_W+HDT_W +: DST_W],
                                                 ID,
                                                 head[DATA_W +: HDT_W]);
                        data_q   <= head[DATA_W-1:0];
                        req_q    <= 1'b1;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tx_ack_i) begin
                        req_q   <= 1'b0;
                        state_q <= ST_REL;
                    end else if (timeout | ~link_ready_i) begin
                        req_q   <= 1'b0;
                        state_q <= ST_ABORT;
                    end else begin
                        timer_q <= timer_q + 10'd1;
                    end
                end
                ST_REL: begin
                    if (~tx_ack_i) state_q <= ST_IDLE;
                end
                default: begin
                    if (~tx_ack_i) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_req_o    = req_q;
    assign tx_header_o = header_q;
    assign tx_data_o   = data_q;
    assign err_cnt_o   = err_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_tnet_tx_queue.sv
// Directed bench for tnet_tx_queue: single transfer, fill, timeout, link drop and mid-handshake reset.
module tb_tnet_tx_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id;
    logic        link_ready;
    logic        valid;
    logic        ready;
    logic [3:0]  op;
    logic [5:0]  flags;
    logic [9:0]  dst;
    logic [19:0] hdt;
    logic [63:0] data;
    logic        req;
    logic [63:0] header;
    logic [63:0] tx_data;
    logic        ack;
    logic [2:0]  q_cnt;
    logic [7:0]  err_cnt;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tnet_tx_queue #(.DEPTH_LOG2(2), .ACK_TO(1023)) dut (
        .user_clk_i    (clk),
        .user_rst_i    (rst),
        .ID            (id),
        .link_ready_i  (link_ready),
        .s_cmd_valid_i (valid),
        .s_cmd_ready_o (ready),
        .s_cmd_op_i    (op),
        .s_cmd_flags_i (flags),
        .s_cmd_dst_i   (dst),
        .s_cmd_hdt_i   (hdt),
        .s_cmd_data_i  (data),
        .tx_req_o      (req),
        .tx_header_o   (header),
        .tx_data_o     (tx_data),
        .tx_ack_i      (ack),
        .q_cnt_o       (q_cnt),
        .err_cnt_o     (err_cnt),
        .state_o       (state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Independent header model: {4'b0, op, flags, dst, src, 10'b0, hdt}
    function automatic logic [63:0] hdr(input logic [3:0] o, input logic [5:0] f,
                                        input logic [9:0] d, input logic [9:0] s,
                                        input logic [19:0] h);
        return {4'h0, o, f, d, s, 10'h000, h};
    endfunction

    task automatic push(input logic [3:0] o, input logic [5:0] f, input logic [9:0] d,
                        input logic [19:0] h, input logic [63:0] w, output logic accepted);
        @(negedge clk);
        valid = 1'b1; op = o; flags = f; dst = d; hdt = h; data = w;
        accepted = ready;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {63'd0, seen}, 64'd1);
    endtask

    // Handshake one transfer already in REQ; expects a pop when the link is up.
    task automatic ack_xfer(input string tag, input logic [63:0] exp_h, input logic [63:0] exp_d,
                            input logic [2:0] exp_q);
        check({tag, "_hdr"}, header, exp_h);
        check({tag, "_data"}, tx_data, exp_d);
        ack = 1'b1;
        @(negedge clk);
        check({tag, "_req_low"}, {63'd0, req}, 64'd0);
        check({tag, "_rel"}, {62'd0, state}, 64'd2);
        ack = 1'b0;
        @(negedge clk);
        check({tag, "_qcnt"}, {61'd0, q_cnt}, {61'd0, exp_q});
        check({tag, "_idle"}, {62'd0, state}, 64'd0);
    endtask

    logic        acc;
    int          req_cycles;
    logic [63:0] h1;

    initial begin
        rst = 1'b1; id = 10'd5; link_ready = 1'b0; valid = 1'b0; ack = 1'b0;
        op = '0; flags = '0; dst = '0; hdt = '0; data = '0;
        #12;
        check("rst_req", {63'd0, req}, 64'd0);
        check("rst_hdr", header, 64'd0);
        check("rst_data", tx_data, 64'd0);
        check("rst_ready", {63'd0, ready}, 64'd1);
        check("rst_qcnt", {61'd0, q_cnt}, 64'd0);
        check("rst_err", {56'd0, err_cnt}, 64'd0);
        check("rst_state", {62'd0, state}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single command: one IDLE cycle after the push edge, then REQ
        link_ready = 1'b1;
        push(4'd3, 6'd0, 10'd7, 20'hABCDE, 64'h1122334455667788, acc);
        check("t1_accept", {63'd0, acc}, 64'd1);
        @(negedge clk);
        check("t1_qcnt1", {61'd0, q_cnt}, 64'd1);
        check("t1_req_pre", {63'd0, req}, 64'd0);
        @(negedge clk);
        check("t1_req", {63'd0, req}, 64'd1);
        repeat (3) @(negedge clk);
        ack_xfer("t1", 64'h0300_0701_400A_BCDE, 64'h1122334455667788, 3'd0);

        // Fill with the link down; fifth push is refused
        link_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(4'(i + 1), 6'(i * 9), 10'(100 + i), 20'(32'h10000 + i), 64'hA000_0000_0000_0000 + 64'(i), acc);
            check($sformatf("fill_acc%0d", i), {63'd0, acc}, (i < 4) ? 64'd1 : 64'd0);
        end
        @(negedge clk);
        check("fill_qcnt", {61'd0, q_cnt}, 64'd4);
        check("fill_ready", {63'd0, ready}, 64'd0);
        check("fill_noreq", {63'd0, req}, 64'd0);
        link_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_req($sformatf("fill%0d_reqwait", i));
            ack_xfer($sformatf("fill%0d", i),
                     hdr(4'(i + 1), 6'(i * 9), 10'(100 + i), 10'd5, 20'(32'h10000 + i)),
                     64'hA000_0000_0000_0000 + 64'(i), 3'(3 - i));
            if (i == 0) check("fill_ready_back", {63'd0, ready}, 64'd1);
        end

        // Timeout: timer runs 0..ACK_TO while req is high, then ABORT
        h1 = hdr(4'd9, 6'h20, 10'h3FF, 10'd5, 20'h55555);
        push(4'd9, 6'h20, 10'h3FF, 20'h55555, 64'hDEAD_BEEF_0000_0001, acc);
        wait_req("to_reqwait");
        req_cycles = 0;
        while (req && req_cycles < 1100) begin
            req_cycles++;
            @(negedge clk);
        end
        check("to_cycles", 64'(req_cycles), 64'd1024);
        check("to_state", {62'd0, state}, 64'd3);
        check("to_err", {56'd0, err_cnt}, 64'd1);
        check("to_qcnt", {61'd0, q_cnt}, 64'd1);
        wait_req("to_retry");
        ack_xfer("to_retry", h1, 64'hDEAD_BEEF_0000_0001, 3'd0);

        // Link drop while in REL: no pop, error counted, same header resent
        h1 = hdr(4'd6, 6'h05, 10'd33, 10'd5, 20'h0F0F0);
        push(4'd6, 6'h05, 10'd33, 20'h0F0F0, 64'h0123_4567_89AB_CDEF, acc);
        wait_req("ld_reqwait");
        ack = 1'b1;
        @(negedge clk);
        check("ld_rel", {62'd0, state}, 64'd2);
        link_ready = 1'b0;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        check("ld_qcnt", {61'd0, q_cnt}, 64'd1);
        check("ld_err", {56'd0, err_cnt}, 64'd2);
        check("ld_state", {62'd0, state}, 64'd0);
        link_ready = 1'b1;
        wait_req("ld_retry");
        ack_xfer("ld_retry", h1, 64'h0123_4567_89AB_CDEF, 3'd0);

        // Asynchronous reset in the middle of REQ
        push(4'd2, 6'd1, 10'd2, 20'd2, 64'd2, acc);
        wait_req("rr_reqwait");
        #2 rst = 1'b1;
        #1;
        check("rr_req", {63'd0, req}, 64'd0);
        check("rr_qcnt", {61'd0, q_cnt}, 64'd0);
        check("rr_state", {62'd0, state}, 64'd0);
        check("rr_err", {56'd0, err_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
